// File: rtl/hwpe_stream_tcdm_load_arbiter.sv
// Round-robin arbiter sharing one read-only TCDM master among NB_REQ load requesters,
// with in-order response routing. Optional perf counters: HWPE_TCDM_LOAD_ARB_PERF_EN.

module hwpe_stream_tcdm_load_arbiter_lane #(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned LANE  = 0
) (
  input  logic [IDX_W-1:0] winner_i,
  input  logic             hs_i,
  input  logic [IDX_W-1:0] head_i,
  input  logic             pop_i,
  output logic             gnt_o,
  output logic             r_valid_o
);

  assign gnt_o     = hs_i  & (winner_i == IDX_W'(LANE));
  assign r_valid_o = pop_i & (head_i   == IDX_W'(LANE));

endmodule

module hwpe_stream_tcdm_load_arbiter #(
  parameter int unsigned NB_REQ          = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [NB_REQ-1:0]    s_req_i,
  input  logic [NB_REQ*32-1:0] s_add_i,
  output logic [NB_REQ-1:0]    s_gnt_o,
  output logic [NB_REQ-1:0]    s_r_valid_o,
  output logic [31:0]          s_r_data_o,
  output logic                 m_req_o,
  output logic [31:0]          m_add_o,
  output logic                 m_wen_o,
  output logic [3:0]           m_be_o,
  output logic [31:0]          m_data_o,
  input  logic                 m_gnt_i,
  input  logic                 m_r_valid_i,
  input  logic [31:0]          m_r_data_i,
  output logic                 busy_o,
  output logic                 err_o
`ifdef HWPE_TCDM_LOAD_ARB_PERF_EN
  ,
  output logic [31:0]          perf_stall_o,
  output logic [31:0]          perf_grants_o
`endif
);

  localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NB_REQ-1:0][31:0]           add_arr;
  logic [MAX_OUTSTANDING-1:0][IDX_W-1:0] id_q, id_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] winner, winner_nxt, head;
  logic             id_full, id_empty, hs, pop;

  assign add_arr  = s_add_i;
  assign id_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign id_empty = (cnt_q == '0);
  assign head     = id_q[rd_q];

  // Scan from the priority pointer upward, wrapping; first requester found wins.
  always_comb begin
    logic        found;
    int unsigned cand;
    winner = prio_q;
    found  = 1'b0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = 32'(prio_q) + i;
      if (cand >= NB_REQ) cand = cand - NB_REQ;
      if (!found && s_req_i[cand]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  assign winner_nxt = (winner == IDX_W'(NB_REQ-1)) ? '0 : winner + 1'b1;

  assign m_req_o  = (|s_req_i) & ~id_full;
  assign m_add_o  = add_arr[winner];
  assign m_wen_o  = 1'b1;
  assign m_be_o   = 4'hF;
  assign m_data_o = '0;
  assign hs       = m_req_o & m_gnt_i;
  assign pop      = m_r_valid_i & ~id_empty;

  assign s_r_data_o = m_r_data_i;
  assign busy_o     = ~id_empty;
  assign err_o      = err_q;

  for (genvar l = 0; l < NB_REQ; l++) begin : g_lane
    hwpe_stream_tcdm_load_arbiter_lane #(
      .IDX_W (IDX_W),
      .LANE  (l)
    ) i_lane (
      .winner_i  (winner),
      .hs_i      (hs),
      .head_i    (head),
      .pop_i     (pop),
      .gnt_o     (s_gnt_o[l]),
      .r_valid_o (s_r_valid_o[l])
    );
  end

  always_comb begin
    prio_d = prio_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    id_d   = id_q;
    if (clear_i) begin
      prio_d = '0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
    end else begin
      if (hs) begin
        id_d[wr_q] = winner;
        wr_d       = wr_q + 1'b1;
        prio_d     = winner_nxt;
      end
      if (pop) rd_d = rd_q + 1'b1;
      case ({hs, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      // A response with nothing in flight has no owner: flag it and drop it.
      if (m_r_valid_i && id_empty) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      id_q   <= '0;
    end else begin
      prio_q <= prio_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      id_q   <= id_d;
    end
  end

`ifdef HWPE_TCDM_LOAD_ARB_PERF_EN
  logic [31:0] stall_q, stall_d, grants_q, grants_d;

  always_comb begin
    stall_d  = stall_q;
    grants_d = grants_q;
    if (clear_i) begin
      stall_d  = '0;
      grants_d = '0;
    end else begin
      if ((|s_req_i) && !hs && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (hs && (grants_q != '1))               grants_d = grants_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q  <= '0;
      grants_q <= '0;
    end else begin
      stall_q  <= stall_d;
      grants_q <= grants_d;
    end
  end

  assign perf_stall_o  = stall_q;
  assign perf_grants_o = grants_q;
`endif

endmodule
